uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter with an internal baud divider, configurable frame format and a small transmit FIFO. It replaces the fixed 8N1, externally-strobed transmitter on the serial output path. Producers push characters with a single-cycle write strobe, and the block serialises them back-to-back onto `tx` without software pacing.

## Interface
- `CLK_DIV`, 16: clock cycles per bit period; must be ≥ 2.
- `DATA_BITS`, 8: data bits per frame; legal range 5–9.
- `STOP_BITS`, 1: stop bits per frame; legal values 1 or 2.
- `FIFO_DEPTH`, 4: FIFO entries; power of two, ≥ 2.

- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high reset.
- `wr_en` input 1: push `wr_data` into the FIFO this cycle.
- `wr_data` input `DATA_BITS`: character to transmit, sent LSB first.
- `parity_odd` input 1: 1 selects odd parity, 0 selects even. Ignored unless parity is compiled in.
- `tx` output 1: serial line, idle high.
- `busy` output 1: high when the FSM is not IDLE or the FIFO is non-empty.
- `full` output 1: FIFO holds `FIFO_DEPTH` entries.
- `fifo_count` output `$clog2(FIFO_DEPTH)+1`: current FIFO occupancy.
- `overflow` output 1: sticky flag, set when a write arrives while `full`; cleared only by reset.

## Operation
- FIFO
  - Circular buffer with read and write pointers and an occupancy counter.
  - A write with `full`=0 stores `wr_data` at the write pointer. The pointer wraps modulo `FIFO_DEPTH`.
  - A write with `full`=1 is dropped and sets `overflow`. This holds even if a pop happens in the same cycle.
  - A write and a pop in the same cycle leave `fifo_count` unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `tx`=1. If `fifo_count`>0, pop the head entry into the shift register, clear the baud and bit counters, and go to START.
  - START: `tx`=0 for one bit period, then go to DATA.
  - DATA: `tx` = shift register bit 0. At each bit-period end, shift right. After `DATA_BITS` periods, go to PARITY if parity is compiled in, otherwise go to STOP.
  - PARITY: `tx` = XOR of all data bits, XOR `parity_odd`. Lasts one period, then go to STOP.
  - STOP: `tx`=1 for `STOP_BITS` periods. On the last cycle of the last stop period:
    - if the FIFO is non-empty, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- Baud counter
  - Counts 0 to `CLK_DIV`-1. A bit period ends when the counter equals `CLK_DIV`-1.
  - Reloads to 0 on every state or bit change, so each bit lasts exactly `CLK_DIV` cycles.
- `parity_odd` is sampled when the word is popped. Changes during a frame do not affect that frame.
- `tx` is driven from a register. There is no combinational path from inputs to `tx`.

## Timing
- Reset values: `tx`=1, `busy`=0, `full`=0, `fifo_count`=0, `overflow`=0. FSM is in IDLE, pointers and counters are 0.
- Reset asserted mid-frame: on the next edge `tx` returns to 1. All FIFO contents are discarded. No partial frame resumes.
- Latency from an idle, empty state:
  - `wr_en` sampled at edge k sets `fifo_count`=1 after k.
  - The pop occurs at edge k+1, and `tx` falls to 0 after edge k+1.
- Frame length: (1 + `DATA_BITS` + P + `STOP_BITS`) × `CLK_DIV` cycles, where P=1 with parity and 0 without.
- Back-to-back frames: the next start bit begins the cycle after the last stop-bit cycle.
- `busy` deasserts the cycle after the final stop bit completes, provided the FIFO is empty.
- `full` and `fifo_count` update on the edge following the write or pop.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state is compiled in, and one parity bit is inserted between the data bits and the stop bits.
  - `parity_odd` selects the polarity.
- `UART_TX_PARITY_EN` undefined:
  - The PARITY state and its logic are absent. Frames are start + data + stop.
  - `parity_odd` is unused.

## Test plan
- Reset, then idle with no writes → `tx`=1, `busy`=0, `fifo_count`=0 for 100 cycles.
- `CLK_DIV`=4, `DATA_BITS`=8, `STOP_BITS`=1, no parity; write 0xA5 → `tx` bits 0, 1,0,1,0,0,1,0,1, 1, each held exactly 4 cycles. `busy` drops 40 cycles after the start bit begins.
- Parity enabled, `parity_odd`=0; write 0xA5 → parity bit 0. Same write with `parity_odd`=1 → parity bit 1. Frame is 44 cycles.
- `FIFO_DEPTH`=4; write 0x01–0x05 on consecutive cycles while idle → the first word is popped immediately, so 0x05 is accepted, `full`=1, and `overflow` stays 0. Five frames are sent with no idle gap between stop and start. A further write while `full` sets `overflow`=1 and the dropped byte never appears on `tx`.
- `STOP_BITS`=2, `DATA_BITS`=5; write 0x1F → start, 5 ones, then 2 stop periods. The line is high for 7×`CLK_DIV` cycles after the start bit.
- Assert `reset` in the middle of the 3rd data bit with 2 words queued → `tx`=1 and `fifo_count`=0 the cycle after reset. No further frames are sent.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with baud divider; define UART_TX_PARITY_EN to insert a parity bit
module uart_tx_fifo #(
   parameter int CLK_DIV    = 16,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          wr_en,
   input  logic [DATA_BITS-1:0]          wr_data,
   input  logic                          parity_odd,
   output logic                          tx,
   output logic                          busy,
   output logic                          full,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(CLK_DIV);
   localparam int NW = $clog2(DATA_BITS + 1);
   typedef enum logic [2:0] {IDLE, START, DATA, `ifdef UART_TX_PARITY_EN PARITY, `endif STOP} state_t;
   state_t               state;
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wptr, rptr;
   logic [BW-1:0]        baud;
   logic [NW-1:0]        bitn;
   logic [DATA_BITS-1:0] shreg;
   logic                 nonempty, push, pop, bit_end, last_stop;
`ifdef UART_TX_PARITY_EN
   logic                 par;
`else
   logic                 unused_parity;
   assign unused_parity = parity_odd;
`endif
   assign nonempty  = fifo_count != '0;
   assign full      = fifo_count == (AW+1)'(FIFO_DEPTH);
   assign push      = wr_en && !full;
   assign bit_end   = baud == BW'(CLK_DIV - 1);
   assign last_stop = state == STOP && bit_end && bitn == NW'(STOP_BITS - 1);
   assign pop       = nonempty && (state == IDLE || last_stop);
   assign busy      = state != IDLE || nonempty;
   // FIFO storage; writes only land when there is room
   always_ff @(posedge clk)
      if (push) mem[wptr] <= wr_data;
   // FIFO pointers, occupancy and the sticky overflow flag
   always_ff @(posedge clk)
      if (reset) begin
         wptr       <= '0;
         rptr       <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
         fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
         overflow   <= overflow | (wr_en & full);
      end
   // Frame sequencer with registered tx; a pop always restarts at the start bit
   always_ff @(posedge clk)
      if (reset) begin
         state <= IDLE;
         tx    <= 1'b1;
         baud  <= '0;
         bitn  <= '0;
         shreg <= '0;
`ifdef UART_TX_PARITY_EN
         par   <= 1'b0;
`endif
      end else begin
         baud <= (state == IDLE || bit_end) ? '0 : baud + 1'b1;
         if (pop) begin
            state <= START;
            tx    <= 1'b0;
            bitn  <= '0;
            shreg <= mem[rptr];
`ifdef UART_TX_PARITY_EN
            par   <= ^mem[rptr] ^ parity_odd;
`endif
         end else if (bit_end)
            case (state)
               START: begin
                  state <= DATA;
                  tx    <= shreg[0];
               end
               DATA: begin
                  shreg <= shreg >> 1;
                  if (bitn == NW'(DATA_BITS - 1)) begin
                     bitn  <= '0;
`ifdef UART_TX_PARITY_EN
                     state <= PARITY;
                     tx    <= par;
`else
                     state <= STOP;
                     tx    <= 1'b1;
`endif
                  end else begin
                     bitn <= bitn + 1'b1;
                     tx   <= shreg[1];
                  end
               end
`ifdef UART_TX_PARITY_EN
               PARITY: begin
                  state <= STOP;
                  tx    <= 1'b1;
               end
`endif
               STOP: begin
                  if (bitn == NW'(STOP_BITS - 1)) state <= IDLE;
                  else bitn <= bitn + 1'b1;
               end
               default: ;
            endcase
      end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of framing, FIFO, back-to-back, stop bits and mid-frame reset
module tb_uart_tx_fifo;
   localparam int CD = 4;
`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int L0 = (1 + 8 + PAR + 1) * CD;
   localparam int L1 = (1 + 5 + PAR + 2) * CD;
   logic       clk = 1'b0, reset = 1'b1, wr_en = 1'b0, wr_en1 = 1'b0, parity_odd = 1'b0;
   logic [7:0] wr_data = '0;
   logic [4:0] wr_data1 = '0;
   logic       tx, busy, full, overflow, tx1, busy1, full1, overflow1;
   logic [2:0] fifo_count, fifo_count1;
   logic       c_tx [512], c_busy [512], c_tx1 [512], c_busy1 [512];
   int         n_checks = 0, n_fail = 0;

   uart_tx_fifo #(.CLK_DIV(CD), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .parity_odd(parity_odd),
      .tx(tx), .busy(busy), .full(full), .fifo_count(fifo_count), .overflow(overflow));

   uart_tx_fifo #(.CLK_DIV(CD), .DATA_BITS(5), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
      .clk(clk), .reset(reset), .wr_en(wr_en1), .wr_data(wr_data1), .parity_odd(parity_odd),
      .tx(tx1), .busy(busy1), .full(full1), .fifo_count(fifo_count1), .overflow(overflow1));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic fbit(input logic [8:0] d, input int nd, input logic po, input int b);
      logic p;
      p = po;
      for (int k = 0; k < nd; k++) p ^= d[k];
      if (b == 0) return 1'b0;
      if (b <= nd) return d[b-1];
      if (PAR == 1 && b == nd + 1) return p;
      return 1'b1;
   endfunction

   task automatic grab(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         c_tx[i] = tx;
         c_busy[i] = busy;
         c_tx1[i] = tx1;
         c_busy1[i] = busy1;
      end
   endtask

   task automatic push(input logic [7:0] d);
      wr_en = 1'b1;
      wr_data = d;
      @(posedge clk);
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rst_tx: got %b want 1", tx); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b want 0", full); end
      n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b want 0", overflow); end
      n_checks++; if (tx1 !== 1'b1) begin n_fail++; $display("FAIL rst_tx1: got %b want 1", tx1); end
      reset = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         n_checks++;
         if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL idle cycle %0d: tx=%b busy=%b count=%0d want 1 0 0", i, tx, busy, fifo_count);
         end
      end
   endtask

   task automatic test_single;
      parity_odd = 1'b0;
      push(8'hA5);
      n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", fifo_count); end
      n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL single_tx_pre: got %b want 1", tx); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
      grab(L0 + 1);
      for (int i = 0; i < L0; i++) begin
         n_checks++;
         if (c_tx[i] !== fbit(9'h0A5, 8, 1'b0, i / CD) || c_busy[i] !== 1'b1) begin
            n_fail++;
            $display("FAIL single_frame cycle %0d: tx=%b busy=%b want %b 1", i, c_tx[i], c_busy[i], fbit(9'h0A5, 8, 1'b0, i / CD));
         end
      end
      n_checks++; if (c_busy[L0] !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", c_busy[L0]); end
      n_checks++; if (c_tx[L0] !== 1'b1) begin n_fail++; $display("FAIL single_tx_end: got %b want 1", c_tx[L0]); end
   endtask

   task automatic test_parity;
      parity_odd = 1'b1;
      push(8'hA5);
      @(negedge clk);
      n_checks++; if (tx !== 1'b0) begin n_fail++; $display("FAIL par_start: got %b want 0", tx); end
      parity_odd = 1'b0;
      grab(L0);
      for (int i = 0; i < L0 - 1; i++) begin
         n_checks++;
         if (c_tx[i] !== fbit(9'h0A5, 8, 1'b1, (i + 1) / CD)) begin
            n_fail++;
            $display("FAIL par_frame cycle %0d: got %b want %b", i + 1, c_tx[i], fbit(9'h0A5, 8, 1'b1, (i + 1) / CD));
         end
      end
      n_checks++; if (c_busy[L0-1] !== 1'b0) begin n_fail++; $display("FAIL par_busy_end: got %b want 0", c_busy[L0-1]); end
   endtask

   task automatic test_back_to_back;
      int  g, f;
      logic e;
      wr_en = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         wr_data = 8'(i);
         @(posedge clk);
         @(negedge clk);
      end
      wr_en = 1'b0;
      n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL b2b_full: got %b want 1", full); end
      n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", fifo_count); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_no_overflow: got %b want 0", overflow); end
      n_checks++; if (tx !== 1'b0) begin n_fail++; $display("FAIL b2b_start: got %b want 0", tx); end
      push(8'h77);
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL b2b_overflow: got %b want 1", overflow); end
      n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL b2b_count_drop: got %0d want 4", fifo_count); end
      grab(6 * L0 - 5);
      for (int j = 0; j < 6 * L0 - 5; j++) begin
         g = j + 5;
         f = g / L0;
         e = (f < 5) ? fbit(9'(f + 1), 8, 1'b0, (g % L0) / CD) : 1'b1;
         n_checks++;
         if (c_tx[j] !== e || c_busy[j] !== (g < 5 * L0)) begin
            n_fail++;
            $display("FAIL b2b_stream cycle %0d: tx=%b busy=%b want %b %b", g, c_tx[j], c_busy[j], e, g < 5 * L0);
         end
      end
      n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL b2b_count_end: got %0d want 0", fifo_count); end
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL b2b_sticky: got %b want 1", overflow); end
   endtask

   task automatic test_stop2;
      int hi;
      wr_en1 = 1'b1;
      wr_data1 = 5'h1F;
      @(posedge clk);
      @(negedge clk);
      wr_en1 = 1'b0;
      n_checks++; if (fifo_count1 !== 3'd1) begin n_fail++; $display("FAIL stop2_count: got %0d want 1", fifo_count1); end
      grab(L1 + 1);
      hi = 0;
      for (int i = 0; i < L1; i++) begin
         if (c_tx1[i] === 1'b1) hi++;
         n_checks++;
         if (c_tx1[i] !== fbit(9'h01F, 5, 1'b0, i / CD)) begin
            n_fail++;
            $display("FAIL stop2_frame cycle %0d: got %b want %b", i, c_tx1[i], fbit(9'h01F, 5, 1'b0, i / CD));
         end
      end
      n_checks++; if (c_tx1[0] !== 1'b0) begin n_fail++; $display("FAIL stop2_start: got %b want 0", c_tx1[0]); end
      n_checks++; if (hi !== L1 - CD) begin n_fail++; $display("FAIL stop2_high: got %0d want %0d", hi, L1 - CD); end
      n_checks++; if (c_busy1[L1-1] !== 1'b1 || c_busy1[L1] !== 1'b0) begin n_fail++; $display("FAIL stop2_busy: got %b%b want 10", c_busy1[L1-1], c_busy1[L1]); end
      n_checks++; if (overflow1 !== 1'b0 || full1 !== 1'b0) begin n_fail++; $display("FAIL stop2_flags: got %b%b want 00", overflow1, full1); end
   endtask

   task automatic test_reset_mid;
      wr_en = 1'b1;
      wr_data = 8'h11; @(posedge clk); @(negedge clk);
      wr_data = 8'h22; @(posedge clk); @(negedge clk);
      wr_data = 8'h33; @(posedge clk); @(negedge clk);
      wr_en = 1'b0;
      n_checks++; if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL rmid_queued: got %0d want 2", fifo_count); end
      repeat (12) @(negedge clk);
      n_checks++; if (tx !== fbit(9'h011, 8, 1'b0, 3)) begin n_fail++; $display("FAIL rmid_bit2: got %b want %b", tx, fbit(9'h011, 8, 1'b0, 3)); end
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rmid_tx: got %b want 1", tx); end
      n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL rmid_count: got %0d want 0", fifo_count); end
      n_checks++; if (busy !== 1'b0 || full !== 1'b0) begin n_fail++; $display("FAIL rmid_flags: busy=%b full=%b want 0 0", busy, full); end
      reset = 1'b0;
      for (int i = 0; i < 3 * L0; i++) begin
         @(negedge clk);
         n_checks++;
         if (tx !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_quiet cycle %0d: tx=%b busy=%b want 1 0", i, tx, busy);
         end
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_parity;
      test_back_to_back;
      test_stop2;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
